// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an iterative shift-add multiplier and restoring divider.
// One iteration per cycle; a FIX cycle applies sign correction and writes HI/LO.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]    a_q, a_d;      // |multiplicand|, or |dividend| shifting into quotient
  logic [WIDTH-1:0]    b_q, b_d;      // |multiplier| (shifts right), or |divisor|
  logic [2*WIDTH-1:0]  acc_q, acc_d;  // product, or remainder in the upper half
  logic                is_div_q, is_div_d;
  logic                neg_lo_q, neg_lo_d;
  logic                neg_rem_q, neg_rem_d;
  logic                div0_q, div0_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                done_q, done_d;

  logic                is_signed, a_neg, b_neg;
  logic [WIDTH:0]      mul_sum, rem_shift, div_diff;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){b_q[0]}});
  assign rem_shift = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
  assign div_diff  = rem_shift - {1'b0, b_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    is_signed = ~op[0];
    a_neg     = is_signed & op_a[WIDTH-1];
    b_neg     = is_signed & op_b[WIDTH-1];

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          case (op)
            3'd4: hi_d = op_a;
            3'd5: lo_d = op_a;
            3'd0, 3'd1, 3'd2, 3'd3: begin
              a_d       = a_neg ? -op_a : op_a;
              b_d       = b_neg ? -op_b : op_b;
              acc_d     = '0;
              cnt_d     = '0;
              is_div_d  = op[1];
              neg_lo_d  = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              div0_d    = op[1] & (op_b == '0);
              state_d   = StCalc;
            end
            default: ;
          endcase
        end
      end
      StCalc: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          if (is_div_q) begin
            // Restore when the trial subtraction goes negative.
            acc_d[2*WIDTH-1:WIDTH] = div_diff[WIDTH] ? rem_shift[WIDTH-1:0]
                                                     : div_diff[WIDTH-1:0];
            a_d = {a_q[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            b_d   = b_q >> 1;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!abort) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Zero divisor leaves |a| as remainder, so hi restores op_a after sign fix.
            lo_d = div0_q ? '1 : (neg_lo_q ? -a_q : a_q);
            hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end else begin
            {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: issued mul/div ops push expected {hi,lo};
// a monitor pops and compares on every done pulse.
module tb_hilo_muldiv_unit;

  localparam int unsigned W = 32;
  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] op_a, op_b;
  logic         abort;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_v;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .op_a    (op_a),
    .op_b    (op_b),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with no op outstanding, expected done=0");
      end else begin
        exp_v = exp_q.pop_front();
        check("result_hi", hi, exp_v[2*W-1:W]);
        check("result_lo", lo, exp_v[W-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; start is seen by the next posedge (E0).
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_timeout: got busy=%b after %0d cycles, expected 0", busy, cyc);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int cyc;
    exp_q.push_back({ehi, elo});
    issue(o, a, b);
    check_bit("busy_after_accept", busy, 1'b1);
    wait_idle(cyc);
    check("latency", cyc, W + 1);
    check_bit("done_pulse", done, 1'b1);
    @(negedge clk);
    check_bit("done_clear", done, 1'b0);
  endtask

  initial begin
    int cyc;
    start   = 1'b0;
    op      = 3'd0;
    op_a    = '0;
    op_b    = '0;
    abort   = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Multiply
    run_op(OpMult,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(OpMult,  32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0014);
    // Divide, including signed negative divisor and special cases
    run_op(OpDiv,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(OpDivu,  32'd7,         32'd2,        32'd1,         32'd3);
    run_op(OpDiv,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    run_op(OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op(OpDivu,  32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF);
    run_op(OpDiv,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MTHI / MTLO back to back: registered update, no busy, no done
    start = 1'b1;
    op    = OpMthi;
    op_a  = 32'h1234_5678;
    #1;
    check("mthi_not_comb", hi, 32'hFFFF_FFF9);
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234_5678);
    check_bit("mthi_busy", busy, 1'b0);
    op   = OpMtlo;
    op_a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_hi_kept", hi, 32'h1234_5678);
    check_bit("mtlo_busy", busy, 1'b0);
    @(negedge clk);

    // Start while busy is ignored
    exp_q.push_back({32'd0, 32'd42});
    issue(OpMult, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    issue(OpDivu, 32'd9, 32'd3);
    wait_idle(cyc);
    check_bit("ignored_start_done", done, 1'b1);
    @(negedge clk);

    // Abort mid-calculation: no write, no done
    issue(OpMult, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_done", done, 1'b0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd42);
    repeat (40) @(negedge clk);
    check_bit("abort_stays_idle", busy, 1'b0);

    // Reset mid-operation
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_hi", hi, '0);
    check("midreset_lo", lo, '0);
    check_bit("midreset_busy", busy, 1'b0);
    check_bit("midreset_done", done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(OpMultu, 32'd2, 32'd3, 32'd0, 32'd6);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding results, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
